temporal_mxu: RTL and testbench

- Matrix multiply unit computing C = A x B for DIM x DIM unsigned matrices in temporal (unary) form.
- Each A element is streamed as a thermometer code over time; B elements are added conditionally each cycle.
- Trades latency (2^BIT_WIDTH cycles) for multiplier-free datapath.
- Sits as an accelerator tile: host loads A/B, pulses start, waits for out_valid.

---
 rtl/temporal_mxu_pkg.sv | 27 ++
 rtl/temporal_mxu_pe.sv | 40 ++++
 rtl/temporal_mxu.sv | 125 ++++++++++++
 tb/tb_temporal_mxu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/temporal_mxu_pkg.sv
// temporal_mxu shared types and width helpers.
// Optional early termination: TEMPORAL_MXU_EARLY_TERM_EN.
package temporal_mxu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_BW = 8;
  localparam int ACC_W  = 2 * DEF_BW;
  localparam int T_MAX  = (1 << DEF_BW) - 1;

  function automatic int acc_w(input int bw);
    return 2 * bw;
  endfunction

  function automatic int t_max(input int bw);
    return (1 << bw) - 1;
  endfunction

  function automatic int cnt_w(input int bw);
    return $clog2(t_max(bw) + 1);
  endfunction

endpackage

// File: rtl/temporal_mxu_pe.sv
// temporal_mxu processing element: one C entry.
// Adds B[k] whenever t is still below A[k] (thermometer test).
module temporal_mxu_pe
  import temporal_mxu_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int DIM       = 16,
  parameter int AW        = acc_w(BIT_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [DIM*BIT_WIDTH-1:0] a_row,
  input  logic [DIM*BIT_WIDTH-1:0] b_col,
  input  logic [BIT_WIDTH-1:0]     t,
  output logic [AW-1:0]            acc
);

  localparam int PS_W = BIT_WIDTH + $clog2(DIM) + 1;

  logic [PS_W-1:0] psum;

  always_comb begin
    psum = '0;
    for (int k = 0; k < DIM; k++) begin
      if (t < a_row[k*BIT_WIDTH +: BIT_WIDTH])
        psum = psum + PS_W'(b_col[k*BIT_WIDTH +: BIT_WIDTH]);
    end
  end

  // partial sum kept at full width, truncated only on the add
  always_ff @(posedge clk) begin
    if (reset || clear)
      acc <= '0;
    else if (enable)
      acc <= acc + AW'(psum);
  end

endmodule

// File: rtl/temporal_mxu.sv
// temporal_mxu: DIM x DIM unary-time matrix multiply.
// Optional early termination: TEMPORAL_MXU_EARLY_TERM_EN.
module temporal_mxu
  import temporal_mxu_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int DIM       = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DIM*DIM*BIT_WIDTH-1:0]     A,
  input  logic [DIM*DIM*BIT_WIDTH-1:0]     B,
  output logic                             out_valid,
  output logic [DIM*DIM*2*BIT_WIDTH-1:0]   out
);

  localparam int AW = acc_w(BIT_WIDTH);
  localparam int TM = t_max(BIT_WIDTH);
  localparam int CW = cnt_w(BIT_WIDTH);
  localparam int RW = DIM * BIT_WIDTH;

  state_t state, state_nxt;

  logic [CW-1:0]              t;
  logic [CW-1:0]              t_last;
  logic [DIM*DIM*BIT_WIDTH-1:0] a_q;
  logic [DIM*DIM*BIT_WIDTH-1:0] b_q;
  logic [DIM*DIM*AW-1:0]      acc_all;
  logic                       take;
  logic                       run;

  assign take = (state == IDLE) && start;
  assign run  = (state == RUN);

`ifdef TEMPORAL_MXU_EARLY_TERM_EN
  logic [BIT_WIDTH-1:0] max_a;
  logic [BIT_WIDTH-1:0] max_q;

  always_comb begin
    max_a = '0;
    for (int e = 0; e < DIM*DIM; e++) begin
      if (A[e*BIT_WIDTH +: BIT_WIDTH] > max_a)
        max_a = A[e*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  assign t_last = CW'(max_q - 1'b1);
`else
  assign t_last = CW'(TM - 1);
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
`ifdef TEMPORAL_MXU_EARLY_TERM_EN
          if (max_a == '0)
            state_nxt = DONE;
`endif
        end
      end
      RUN:     if (t == t_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      t         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef TEMPORAL_MXU_EARLY_TERM_EN
      max_q     <= '0;
`endif
    end else begin
      state     <= state_nxt;
      out_valid <= (state == DONE);
      if (state == DONE)
        out <= acc_all;
      if (take) begin
        a_q <= A;
        b_q <= B;
        t   <= '0;
`ifdef TEMPORAL_MXU_EARLY_TERM_EN
        max_q <= max_a;
`endif
      end else if (run) begin
        t <= t + 1'b1;
      end
    end
  end

  // B columns are gathered once and shared down each column of PEs
  for (genvar j = 0; j < DIM; j++) begin : g_col
    logic [RW-1:0] bcol;
    for (genvar k = 0; k < DIM; k++) begin : g_k
      assign bcol[k*BIT_WIDTH +: BIT_WIDTH] =
        b_q[(k*DIM+j)*BIT_WIDTH +: BIT_WIDTH];
    end
    for (genvar i = 0; i < DIM; i++) begin : g_row
      temporal_mxu_pe #(
        .BIT_WIDTH (BIT_WIDTH),
        .DIM       (DIM),
        .AW        (AW)
      ) u_pe (
        .clk    (clk),
        .reset  (reset),
        .clear  (take),
        .enable (run),
        .a_row  (a_q[i*RW +: RW]),
        .b_col  (bcol),
        .t      (t),
        .acc    (acc_all[(i*DIM+j)*AW +: AW])
      );
    end
  end

endmodule

// File: tb/tb_temporal_mxu.sv
// temporal_mxu directed bench across several DIM/BIT_WIDTH builds.
// Latencies follow TEMPORAL_MXU_EARLY_TERM_EN when defined.
module tb_temporal_mxu;

`ifdef TEMPORAL_MXU_EARLY_TERM_EN
  localparam int L16_ONES = 2;
  localparam int L4_14    = 15;
  localparam int L8_A     = 4;
  localparam int L8_Z     = 1;
`else
  localparam int L16_ONES = 256;
  localparam int L4_14    = 16;
  localparam int L8_A     = 256;
  localparam int L8_Z     = 256;
`endif
  localparam int L2    = 4;
  localparam int L4_15 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16, rst2, rst_o;
  logic st16, st2, st4, st8;
  logic v16, v2, v4, v8;

  logic [16*16*8-1:0]  a16, b16;
  logic [16*16*16-1:0] o16;
  logic [2*2*2-1:0]    a2, b2;
  logic [2*2*4-1:0]    o2;
  logic [2*2*4-1:0]    a4, b4;
  logic [2*2*8-1:0]    o4;
  logic [2*2*8-1:0]    a8, b8;
  logic [2*2*16-1:0]   o8;

  temporal_mxu #(.BIT_WIDTH(8), .DIM(16)) u16 (
    .clk(clk), .reset(rst16), .start(st16),
    .A(a16), .B(b16), .out_valid(v16), .out(o16));

  temporal_mxu #(.BIT_WIDTH(2), .DIM(2)) u2 (
    .clk(clk), .reset(rst2), .start(st2),
    .A(a2), .B(b2), .out_valid(v2), .out(o2));

  temporal_mxu #(.BIT_WIDTH(4), .DIM(2)) u4 (
    .clk(clk), .reset(rst_o), .start(st4),
    .A(a4), .B(b4), .out_valid(v4), .out(o4));

  temporal_mxu #(.BIT_WIDTH(8), .DIM(2)) u8 (
    .clk(clk), .reset(rst_o), .start(st8),
    .A(a8), .B(b8), .out_valid(v8), .out(o8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic vld(input int w);
    case (w)
      0:       return v16;
      1:       return v2;
      2:       return v4;
      default: return v8;
    endcase
  endfunction

  task automatic wait_valid(input int w, input int bound, output int n);
    n = -1;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk); #1;
      if (vld(w)) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic count_valid(input int w, input int cyc, output int cnt);
    cnt = 0;
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk); #1;
      if (vld(w)) cnt++;
    end
  endtask

  task automatic pulse(input int w);
    @(negedge clk);
    case (w)
      0:       st16 = 1'b1;
      1:       st2  = 1'b1;
      2:       st4  = 1'b1;
      default: st8  = 1'b1;
    endcase
    @(posedge clk); #1;
    st16 = 1'b0; st2 = 1'b0; st4 = 1'b0; st8 = 1'b0;
  endtask

  task automatic fill16(input logic [7:0] av, input logic [7:0] bv);
    for (int e = 0; e < 256; e++) begin
      a16[e*8 +: 8] = av;
      b16[e*8 +: 8] = bv;
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] exp);
    int bad;
    bad = 0;
    for (int e = 0; e < 256; e++)
      if (o16[e*16 +: 16] !== exp) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  int n, cnt;

  initial begin
    rst16 = 1'b1; rst2 = 1'b1; rst_o = 1'b1;
    st16 = 1'b0; st2 = 1'b0; st4 = 1'b0; st8 = 1'b0;
    a16 = '0; b16 = '0; a2 = '0; b2 = '0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst16 = 1'b0; rst2 = 1'b0; rst_o = 1'b0;

    chk("rst_v16", 64'(v16), 64'd0);
    chk("rst_o16", 64'(|o16), 64'd0);
    chk("rst_v2", 64'(v2), 64'd0);

    // all ones, 16x16: every entry 16
    fill16(8'd1, 8'd1);
    pulse(0);
    wait_valid(0, 400, n);
    chk("ones_lat", 64'(n), 64'(L16_ONES));
    chk16("ones_out", 16'd16);
    chk("ones_e0", 64'(o16[15:0]), 64'd16);
    @(posedge clk); #1;
    chk("ones_pulse", 64'(v16), 64'd0);

    // 2x2, 2-bit
    a2 = {2'd0, 2'd3, 2'd2, 2'd1};
    b2 = {2'd2, 2'd0, 2'd2, 2'd2};
    pulse(1);
    wait_valid(1, 50, n);
    chk("m2_lat", 64'(n), 64'(L2));
    chk("m2_c00", 64'(o2[0  +: 4]), 64'd2);
    chk("m2_c01", 64'(o2[4  +: 4]), 64'd6);
    chk("m2_c10", 64'(o2[8  +: 4]), 64'd6);
    chk("m2_c11", 64'(o2[12 +: 4]), 64'd6);

    // 2x2, 4-bit all 15: 450 wraps to 194
    a4 = {4{4'd15}};
    b4 = {4{4'd15}};
    pulse(2);
    wait_valid(2, 50, n);
    chk("wrap_lat", 64'(n), 64'(L4_15));
    for (int e = 0; e < 4; e++)
      chk("wrap_c", 64'(o4[e*8 +: 8]), 64'd194);

    // operands latched; start during RUN ignored
    a4 = {4{4'd14}};
    b4 = {4{4'd1}};
    pulse(2);
    a4 = {4{4'd3}};
    b4 = {4{4'd3}};
    repeat (5) @(posedge clk);
    pulse(2);
    wait_valid(2, 50, n);
    chk("ign_lat", 64'(n + 6), 64'(L4_14));
    for (int e = 0; e < 4; e++)
      chk("ign_c", 64'(o4[e*8 +: 8]), 64'd28);
    count_valid(2, 30, cnt);
    chk("ign_extra", 64'(cnt), 64'd0);

    // reset aborts a run
    fill16(8'd200, 8'd1);
    pulse(0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0;
    chk("abort_o16", 64'(|o16), 64'd0);
    chk("abort_v16", 64'(v16), 64'd0);
    count_valid(0, 300, cnt);
    chk("abort_novld", 64'(cnt), 64'd0);
    fill16(8'd1, 8'd1);
    pulse(0);
    wait_valid(0, 400, n);
    chk("rerun_lat", 64'(n), 64'(L16_ONES));
    chk16("rerun_out", 16'd16);

    // reset and start together: reset wins
    @(negedge clk);
    rst2 = 1'b1;
    st2  = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    st2  = 1'b0;
    chk("rs_o2", 64'(o2), 64'd0);
    count_valid(1, 10, cnt);
    chk("rs_novld", 64'(cnt), 64'd0);

    // 2x2, 8-bit: small max A
    a8 = {8'd0, 8'd3, 8'd2, 8'd1};
    b8 = {8'd2, 8'd0, 8'd2, 8'd2};
    pulse(3);
    wait_valid(3, 400, n);
    chk("et_lat", 64'(n), 64'(L8_A));
    chk("et_c00", 64'(o8[0  +: 16]), 64'd2);
    chk("et_c01", 64'(o8[16 +: 16]), 64'd6);
    chk("et_c10", 64'(o8[32 +: 16]), 64'd6);
    chk("et_c11", 64'(o8[48 +: 16]), 64'd6);

    // all-zero A
    a8 = '0;
    b8 = {4{8'd9}};
    pulse(3);
    wait_valid(3, 400, n);
    chk("zero_lat", 64'(n), 64'(L8_Z));
    chk("zero_out", 64'(o8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
